seg7_display_ctrl: RTL and testbench



---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_display_ctrl_if.sv | 22 ++
 rtl/seg7_font_decode.sv | 11 +
 rtl/seg7_display_ctrl.sv | 140 ++++++++++++++
 tb/tb_seg7_display_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display controller: register map,
// CTRL bit positions, hex font and the all-off pattern helper.
package seg7_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_DIGIT0 = 4'd0;
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 4'd14;
  localparam logic [ADDR_W-1:0] ADDR_PACKED = 4'd15;

  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_DECODE_BIT = 1;
  localparam int unsigned CTRL_MASK_LSB   = 8;

  // Active-high g..a patterns; entry 0 sits in the least significant slot.
  localparam logic [15:0][6:0] FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [7:0] all_off(input logic active_low);
    return active_low ? 8'hFF : 8'h00;
  endfunction

endpackage

// File: rtl/seg7_display_ctrl_if.sv
// Avalon-MM slave bus bundle for the seven-segment display controller.
interface seg7_display_ctrl_if;
  import seg7_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic              read_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, chipselect, write_n, read_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, read_n, writedata,
    output readdata
  );

endinterface

// File: rtl/seg7_font_decode.sv
// Combinational hex nibble to active-high g..a segment pattern.
module seg7_font_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  assign seg_c = FONT[nibble];

endmodule

// File: rtl/seg7_display_ctrl.sv
// Register-mapped driver for NUM_DIGITS seven-segment digits with decode,
// packed write, global blank and registered readback. Per-digit blinking is
// built only when SEG7_BLINK_EN is defined.
module seg7_display_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter int unsigned BLINK_DIV      = 25000000
) (
  input  logic                    clk,
  input  logic                    reset,
  seg7_display_ctrl_if.slave      bus,
  output logic [8*NUM_DIGITS-1:0] seg_out
);

  localparam int unsigned SEG_W = 8 * NUM_DIGITS;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("seg7_display_ctrl: NUM_DIGITS must be 1..8");
  end
  if (BLINK_DIV < 2 || BLINK_DIV > (1 << 26)) begin : g_bad_blink_div
    $error("seg7_display_ctrl: BLINK_DIV must be 2..2^26");
  end

  logic              wr_en;
  logic              rd_en;
  logic [7:0]        digit [NUM_DIGITS];
  logic              ctrl_en;
  logic              ctrl_decode;
  logic [DATA_W-1:0] rd_value;
  logic [SEG_W-1:0]  seg_next;
  logic [7:0]        digit_pat [NUM_DIGITS];
  logic [6:0]        font_seg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blink_mask;
  logic              blink_phase;

  assign wr_en = bus.chipselect & ~bus.write_n;
  assign rd_en = bus.chipselect & ~bus.read_n;

  // Digit and CTRL registers; a PACKED write loads every digit's nibble.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_DIGITS; k++) digit[k] <= 8'h00;
      ctrl_en     <= 1'b1;
      ctrl_decode <= 1'b1;
    end else if (wr_en) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (bus.address == ADDR_DIGIT0 + ADDR_W'(k)) digit[k] <= bus.writedata[7:0];
        if (bus.address == ADDR_PACKED) digit[k] <= {4'b0000, bus.writedata[4*k +: 4]};
      end
      if (bus.address == ADDR_CTRL) begin
        ctrl_en     <= bus.writedata[CTRL_EN_BIT];
        ctrl_decode <= bus.writedata[CTRL_DECODE_BIT];
      end
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int unsigned CNT_W = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] blink_cnt;

  // Free-running prescaler; CTRL writes leave it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == CNT_MAX) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_mask <= '0;
    end else if (wr_en && bus.address == ADDR_CTRL) begin
      blink_mask <= bus.writedata[CTRL_MASK_LSB +: NUM_DIGITS];
    end
  end
`else
  assign blink_mask  = '0;
  assign blink_phase = 1'b0;
`endif

  // Readback mux; unmapped addresses and unused bits read as zero.
  always_comb begin
    rd_value = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (bus.address == ADDR_DIGIT0 + ADDR_W'(k)) rd_value[7:0] = digit[k];
      if (bus.address == ADDR_PACKED) rd_value[4*k +: 4] = digit[k][3:0];
    end
    if (bus.address == ADDR_CTRL) begin
      rd_value[CTRL_EN_BIT]                 = ctrl_en;
      rd_value[CTRL_DECODE_BIT]             = ctrl_decode;
      rd_value[CTRL_MASK_LSB +: NUM_DIGITS] = blink_mask;
    end
  end

  // Captured on the strobe edge so a same-cycle write reads back the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.readdata <= '0;
    end else if (rd_en) begin
      bus.readdata <= rd_value;
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    logic [7:0] lit;
    logic       blank;

    seg7_font_decode u_font (
      .nibble (digit[k][3:0]),
      .seg_c  (font_seg[k])
    );

    assign lit          = ctrl_decode ? {digit[k][7], font_seg[k]} : digit[k];
    assign blank        = ~ctrl_en | (blink_mask[k] & blink_phase);
    assign digit_pat[k] = blank ? all_off(SEG_ACTIVE_LOW) : (SEG_ACTIVE_LOW ? ~lit : lit);
  end

  always_comb begin
    seg_next = '0;
    for (int k = 0; k < NUM_DIGITS; k++) seg_next[8*k +: 8] = digit_pat[k];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_out <= {NUM_DIGITS{all_off(SEG_ACTIVE_LOW)}};
    end else begin
      seg_out <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Scoreboard bench for seg7_display_ctrl: stimulus queues expected readdata
// and seg_out values, a negedge monitor pops and compares them.
module tb_seg7_display_ctrl;

  localparam logic [63:0] ALL_OFF = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] ALL_0   = 64'hC0C0_C0C0_C0C0_C0C0;
  localparam logic [63:0] BLANK0  = 64'hC0C0_C0C0_C0C0_C0FF;
`ifdef SEG7_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  typedef struct { int cyc; logic [63:0] exp; string name; } seg_chk_t;
  typedef struct { logic [31:0] exp; string name; } rd_chk_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] seg_out;

  seg7_display_ctrl_if bus ();

  seg7_display_ctrl #(
    .NUM_DIGITS     (8),
    .SEG_ACTIVE_LOW (1'b1),
    .BLINK_DIV      (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .seg_out (seg_out)
  );

  always #5 clk = ~clk;

  seg_chk_t seg_q[$];
  rd_chk_t  rd_q[$];
  seg_chk_t sc;
  rd_chk_t  rc;
  int       cyc = 0;
  logic     rd_flag = 1'b0;
  int       tests = 0;
  int       failed = 0;
  int       r0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_flag <= bus.chipselect & ~bus.read_n;
  end

  // Monitor: readdata after every read strobe, seg_out on scheduled cycles.
  always @(negedge clk) begin
    if (rd_flag) begin
      tests++;
      if (rd_q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_read: readdata=%h with no expectation queued", bus.readdata);
      end else begin
        rc = rd_q.pop_front();
        if (bus.readdata !== rc.exp) begin
          failed++;
          $display("FAIL %s: readdata=%h expected=%h", rc.name, bus.readdata, rc.exp);
        end
      end
    end
    while (seg_q.size() != 0 && seg_q[0].cyc <= cyc) begin
      sc = seg_q.pop_front();
      tests++;
      if (sc.cyc != cyc || seg_out !== sc.exp) begin
        failed++;
        $display("FAIL %s: seg_out=%h expected=%h (cycle %0d, due %0d)",
                 sc.name, seg_out, sc.exp, cyc, sc.cyc);
      end
    end
  end

  task automatic idle();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.read_n     = 1'b1;
  endtask

  task automatic expect_seg(input string name, input logic [63:0] exp, input int dly);
    seg_q.push_back('{cyc + dly, exp, name});
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d;
    bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic do_read(input logic [3:0] a, input logic [31:0] exp, input string name);
    rd_q.push_back('{exp, name});
    bus.address = a;
    bus.chipselect = 1'b1; bus.read_n = 1'b0;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic do_rw(input logic [3:0] a, input logic [31:0] d,
                       input logic [31:0] exp, input string name);
    rd_q.push_back('{exp, name});
    bus.address = a; bus.writedata = d;
    bus.chipselect = 1'b1; bus.read_n = 1'b0; bus.write_n = 1'b0;
    @(posedge clk); #1;
    idle();
  endtask

  // Expected seg_out when digit0's mask was set at edge r+1 after a reset at edge r.
  function automatic logic [63:0] blink_exp(input int e, input int r);
    int  x;
    bit  ph;
    x  = e - 1 - r;
    ph = ((x / 4) % 2) == 1;
    return (BLINK_ON && e >= r + 2 && ph) ? BLANK0 : ALL_0;
  endfunction

  initial begin
    bus.address = 4'd0;
    bus.writedata = 32'd0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    expect_seg("reset_all_off", ALL_OFF, 0);
    reset = 1'b0;
    expect_seg("post_reset_zeros", ALL_0, 1);
    @(posedge clk); #1;
    do_read(4'd14, 32'h0000_0003, "ctrl_reset");

    do_write(4'd2, 32'h0000_008A);
    expect_seg("digit2_A_dp", 64'hC0C0_C0C0_C008_C0C0, 1);
    do_read(4'd2, 32'h0000_008A, "digit2_read");

    do_write(4'd14, 32'h0000_0001);
    expect_seg("raw_mode", 64'hFFFF_FFFF_FF75_FFFF, 1);
    do_write(4'd0, 32'h0000_0049);
    expect_seg("raw_digit0", 64'hFFFF_FFFF_FF75_FFB6, 1);
    do_write(4'd14, 32'h0000_0000);
    expect_seg("disabled", ALL_OFF, 1);
    do_read(4'd14, 32'h0000_0000, "ctrl_disabled");
    do_write(4'd14, 32'h0000_0003);
    expect_seg("decode_again", 64'hC0C0_C0C0_C008_C090, 1);

    do_write(4'd15, 32'h1234_5678);
    expect_seg("packed", 64'hF9A4_B099_9282_F880, 1);
    do_read(4'd15, 32'h1234_5678, "packed_read");
    do_read(4'd7, 32'h0000_0001, "digit7_read");
    do_read(4'd2, 32'h0000_0006, "digit2_dp_cleared");

    do_write(4'd10, 32'hFFFF_FFFF);
    expect_seg("ignored_addr", 64'hF9A4_B099_9282_F880, 1);
    do_read(4'd10, 32'h0000_0000, "unmapped10");
    do_read(4'd13, 32'h0000_0000, "unmapped13");

    do_write(4'd1, 32'h0000_0005);
    expect_seg("digit1_5", 64'hF9A4_B099_9282_9280, 1);
    do_rw(4'd1, 32'h0000_0007, 32'h0000_0005, "rw_old_value");
    expect_seg("rw_digit1_7", 64'hF9A4_B099_9282_F880, 1);
    do_read(4'd1, 32'h0000_0007, "digit1_new");

    do_write(4'd14, 32'hFFFF_FF03);
    do_read(4'd14, BLINK_ON ? 32'h0000_FF03 : 32'h0000_0003, "ctrl_unused_bits");
    do_write(4'd14, 32'h0000_0003);

    // Blink: reset, mask digit0, then reset again in the middle of a blank.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    r0 = cyc;
    expect_seg("blink_reset", ALL_OFF, 0);
    for (int e = r0 + 1; e <= r0 + 14; e++) seg_q.push_back('{e, blink_exp(e, r0), "blink_run"});
    do_write(4'd14, 32'h0000_0103);
    do_read(4'd14, BLINK_ON ? 32'h0000_0103 : 32'h0000_0003, "ctrl_mask");
    repeat (12) @(posedge clk);
    #1;
    reset = 1'b1;
    expect_seg("reset_mid_blank", ALL_OFF, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    r0 = cyc;
    expect_seg("blank_ends", ALL_0, 1);
    do_read(4'd14, 32'h0000_0003, "ctrl_after_reset");

    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    r0 = cyc;
    for (int e = r0 + 1; e <= r0 + 10; e++) seg_q.push_back('{e, blink_exp(e, r0), "blink_phase0"});
    do_write(4'd14, 32'h0000_0103);
    repeat (12) @(posedge clk);
    #1;

    while (seg_q.size() != 0) begin
      sc = seg_q.pop_front();
      tests++; failed++;
      $display("FAIL %s: seg check due at cycle %0d never made (now %0d)", sc.name, sc.cyc, cyc);
    end
    while (rd_q.size() != 0) begin
      rc = rd_q.pop_front();
      tests++; failed++;
      $display("FAIL %s: no readdata seen, expected=%h", rc.name, rc.exp);
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, failed);
    $fatal(1, "watchdog expired");
  end

endmodule
